// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types for the calculator operation sequencer
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_e;

endpackage

// File: rtl/calc_op_sequencer_if.sv
// rtl/calc_op_sequencer_if.sv - request/response and shared-datapath bundle of the sequencer
interface calc_op_sequencer_if #(
    parameter int n = 6
);
    import calc_pkg::*;

    logic         start;
    op_e          op;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic [n-1:0] dp_a;
    logic [n-1:0] dp_b;
    logic         dp_sub;
    logic [n-1:0] dp_result;
    logic         busy;
    logic         done;
    logic [n-1:0] result;
    logic [n-1:0] remainder;
    logic         ovf;
    logic         err;

    modport master (
        output start, op, a, b, dp_result,
        input  dp_a, dp_b, dp_sub, busy, done, result, remainder, ovf, err
    );

    modport slave (
        input  start, op, a, b, dp_result,
        output dp_a, dp_b, dp_sub, busy, done, result, remainder, ovf, err
    );

endinterface

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - sequences an external add/sub datapath through ADD, SUB, MUL and DIV
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int n = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    calc_op_sequencer_if.slave   bus
);

    localparam int            CW   = $clog2(n + 1);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    seq_state_e    state_q, state_d;
    op_e           op_q, op_d;
    logic [n-1:0]  a_q, a_d;
    logic [n-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  res_q, res_d;
    logic [n-1:0]  rem_q, rem_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    logic [n-1:0]   dp_a_c, dp_b_c;
    logic           dp_sub_c;
    logic [2*n-1:0] mcand_wide;
    logic [n-1:0]   div_trial;
    logic           div_take;
    logic [CW-1:0]  exit_cnt;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        dp_a_c   = '0;
        dp_b_c   = '0;
        dp_sub_c = 1'b0;

        // MUL keeps A intact and shifts a wide copy; the upper half holds bits lost by truncation.
        mcand_wide = {{n{1'b0}}, a_q} << cnt_q;
        // DIV shifts A left so its MSB is always the next dividend bit; r'[n] is rem_q[n-1].
        div_trial  = {rem_q[n-2:0], a_q[n-1]};
        div_take   = rem_q[n-1] | (div_trial >= b_q);
        exit_cnt   = (op_q == OP_MUL || op_q == OP_DIV) ? LAST : '0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cnt_d   = '0;
                    res_d   = '0;
                    rem_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = RUN;
                    if (bus.op == OP_DIV && bus.b == '0) begin
                        state_d = DONE;
                        res_d   = '1;
                        rem_d   = bus.a;
                        err_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                case (op_q)
                    OP_ADD: begin
                        dp_a_c = a_q;
                        dp_b_c = b_q;
                        res_d  = bus.dp_result;
                        ovf_d  = bus.dp_result < a_q;
                    end
                    OP_SUB: begin
                        dp_a_c   = a_q;
                        dp_b_c   = b_q;
                        dp_sub_c = 1'b1;
                        res_d    = bus.dp_result;
                        ovf_d    = b_q > a_q;
                    end
                    OP_MUL: begin
                        dp_a_c = res_q;
                        dp_b_c = mcand_wide[n-1:0];
                        b_d    = b_q >> 1;
                        if (b_q[0]) begin
                            res_d = bus.dp_result;
                            if (bus.dp_result < res_q || |mcand_wide[2*n-1:n]) begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                    OP_DIV: begin
                        dp_a_c   = div_trial;
                        dp_b_c   = b_q;
                        dp_sub_c = 1'b1;
                        a_d      = a_q << 1;
                        rem_d    = div_take ? bus.dp_result : div_trial;
                        res_d    = {res_q[n-2:0], div_take};
                    end
                endcase
                if (cnt_q == exit_cnt) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bus.dp_a      = dp_a_c;
    assign bus.dp_b      = dp_b_c;
    assign bus.dp_sub    = dp_sub_c;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.remainder = rem_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Multi-cycle operation controller for the calculator ALU.
- Owns one shared n-bit add/subtract datapath, instantiated beside it at calculator top level, and sequences it to execute ADD, SUB, MUL (shift-and-add) and DIV (restoring).
- Sits between the keypad/operand registers and the display path.
- Uses a start/busy/done handshake; all operands are unsigned.

Parameters:
- n, 6, operand/result width in bits (n >= 2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- op  in  2  operation code (calc_pkg::op_e)
- a  in  n  operand A (minuend / multiplicand / dividend)
- b  in  n  operand B (subtrahend / multiplier / divisor)
- dp_a  out  n  shared datapath operand 1
- dp_b  out  n  shared datapath operand 2
- dp_sub  out  1  1 = datapath computes dp_a - dp_b; 0 = dp_a + dp_b
- dp_result  in  n  combinational datapath result, modulo 2^n, same cycle
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- result  out  n  sum / difference / product / quotient
- remainder  out  n  DIV remainder; 0 for other ops
- ovf  out  1  unsigned carry, borrow or product overflow
- err  out  1  divide by zero

Behaviour:
- Single clock with synchronous, active-low reset. While rst_n = 0 at a rising edge: state = IDLE; busy, done, result, remainder, ovf and err = 0. This also applies mid-operation; the in-flight op is discarded.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start = 1 at edge k:
  - Latch a, b and op. Clear ovf, err and the iteration count.
  - Go to RUN (busy = 1 from edge k).
  - Exception: DIV with b = 0 goes directly to DONE with result = all ones, remainder = a, err = 1.
- start while in RUN is ignored.
- DONE lasts one cycle with done = 1, then IDLE. result, remainder, ovf and err hold until the next accepted start.
- ADD:
  - One RUN cycle: dp_a = A, dp_b = B, dp_sub = 0.
  - result <= dp_result; ovf = (dp_result < A).
  - DONE after edge k+1.
- SUB:
  - As ADD with dp_sub = 1; ovf = (B > A) (borrow).
- MUL:
  - n RUN cycles, i = 0..n-1.
  - dp_a = acc, dp_b = mcand_i (A << i, truncated to n bits), dp_sub = 0.
  - If B[i] = 1: acc <= dp_result. ovf is set if the add wraps (dp_result < acc) or any bit of A shifted beyond n-1 was 1.
  - result = acc. DONE after edge k+n.
- DIV:
  - n RUN cycles, processing dividend bits MSB first.
  - Partial remainder: r' = {r, A[n-1-i]}, n+1 bits.
  - dp_a = r'[n-1:0], dp_b = B, dp_sub = 1.
  - If r'[n] = 1 or r'[n-1:0] >= B: r <= dp_result (modulo-2^n result is exact) and quotient bit = 1. Otherwise r <= r'[n-1:0] and quotient bit = 0.
  - result = quotient, remainder = r, ovf = 0. DONE after edge k+n.
- In IDLE and DONE: dp_a = dp_b = 0, dp_sub = 0.
- Iteration counter width: $clog2(n+1). No wrap is possible; RUN exits on count = n-1 for MUL/DIV and count = 0 for ADD/SUB.
- Undefined op values cannot occur (2-bit code is fully decoded).

Decomposition:
- Package calc_pkg:
  - op_e: OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11.
  - seq_state_e: IDLE, RUN, DONE.
- No sub-module: the shared adder/subtractor stays outside, so other calculator logic can reuse the existing addition/subtraction blocks through a top-level mux. Single always_ff FSM plus a combinational datapath-drive block.

Test Plan:
- ADD, n=6: 25+30 -> result 55, ovf 0, done exactly 2 cycles after start. 40+30 -> result 6, ovf 1.
- SUB: 10-3 -> 7, ovf 0. 3-10 -> 57, ovf 1. Check dp_sub = 1 during RUN.
- MUL: 7*9 -> 63, ovf 0, done n+1 = 7 cycles after start. 8*8 -> 0, ovf 1. 0*63 -> 0, ovf 0.
- DIV: 45/7 -> result 6, remainder 3. 63/1 -> 63, remainder 0. 5/9 -> 0, remainder 5. Each with err 0 and 7-cycle latency.
- DIV by zero: 20/0 -> err 1, result 63, remainder 20, done 1 cycle after start, dp outputs stay 0.
- Handshake/reset:
  - start pulsed mid-MUL -> ignored, original product intact.
  - start asserted in the DONE cycle -> new op accepted, busy with no IDLE gap.
  - rst_n = 0 mid-DIV -> next cycle busy 0, done 0, result 0, remainder 0.
